// File: rtl/multicycle_main_control_if.sv
// multicycle_main_control_if: opcode/status inputs and datapath control outputs of the main sequencer.
interface multicycle_main_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;
    modport master (
        input  opcode, zero, mem_ready,
        output mem_read, mem_write, ir_write, iord, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op
    );
    modport slave (
        output opcode, zero, mem_ready,
        input  mem_read, mem_write, ir_write, iord, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op
    );
endinterface

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: fetch/decode/execute/memory/writeback sequencer for the multicycle CPU.
module multicycle_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_main_control_if.master bus
);
    typedef enum logic [3:0] {
        RESET  = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        JUMP   = 4'd12
    } state_t;

    state_t state_q, state_d;
    logic   lw_q, lw_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET;
            lw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lw_q    <= lw_d;
        end
    end

    always_comb begin
        state_d        = RESET;
        lw_d           = lw_q;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.pc_src     = 2'b00;
        bus.pc_en      = 1'b0;
        bus.illegal_op = 1'b0;
        case (state_q)
            RESET: state_d = FETCH;
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
                state_d       = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                // LW vs SW is remembered here so MEMADR need not re-read the opcode
                lw_d          = (bus.opcode == OP_LW);
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d        = FETCH;
                        bus.illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = lw_q ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                state_d      = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = FETCH;
            end
            MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                state_d       = bus.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = ALUWB;
            end
            ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.pc_en     = bus.zero;
                state_d       = FETCH;
            end
            ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = ADDIWB;
            end
            ADDIWB: begin
                bus.reg_write = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = RESET;
        endcase
    end
endmodule
